// File: rtl/cpu_pkg.sv
// Types and defaults shared by the PC, fetch and decode stages.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } fetch_state_t;

  // Counter width able to hold every value 0..limit.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Busy-cycle counter for one memory read; saturates at limit instead of wrapping.
module fetch_timeout_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  // Flags that one more enabled cycle brings the count to limit; depends only
  // on the register so the owner can act on it in the same cycle it enables.
  assign expired = (count == limit - 1'b1);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: takes a PC, reads instruction memory, and holds the word for the decoder.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  PC_IN,
  input  logic               PC_VALID,
  output logic               PC_READY,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic               MEM_READ,
  input  logic [INSTR_W-1:0] MEM_RDATA,
  input  logic               MEM_BUSYWAIT,
  output logic [INSTR_W-1:0] INSTR,
  output logic [ADDR_W-1:0]  INSTR_PC,
  output logic               INSTR_VALID,
  input  logic               INSTR_READY,
  input  logic               FLUSH,
  output logic               FETCH_ERR
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  fetch_state_t       state, state_nx;
  logic [ADDR_W-1:0]  mem_addr_nx, instr_pc_nx;
  logic [INSTR_W-1:0] instr_nx;
  logic               mem_read_nx, instr_valid_nx, fetch_err_nx;
  logic               cnt_clear, cnt_enable, cnt_expired;
  logic               pc_accept;

  fetch_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk     (CLK),
    .rst_n   (RESET),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit   (CNT_W'(TIMEOUT)),
    .expired (cnt_expired)
  );

  assign PC_READY  = !FLUSH && ((state == IDLE) || ((state == HOLD) && INSTR_READY));
  assign pc_accept = PC_READY && PC_VALID;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nx       = state;
    mem_addr_nx    = MEM_ADDR;
    instr_pc_nx    = INSTR_PC;
    instr_nx       = INSTR;
    mem_read_nx    = MEM_READ;
    instr_valid_nx = INSTR_VALID;
    fetch_err_nx   = FETCH_ERR;
    cnt_clear      = 1'b0;
    cnt_enable     = 1'b0;

    unique case (state)
      IDLE: ;
      REQ: begin
        if (FLUSH) begin
          if (MEM_BUSYWAIT) begin
            state_nx  = DRAIN;
            cnt_clear = 1'b1;
          end else begin
            mem_read_nx = 1'b0;
            state_nx    = IDLE;
          end
        end else if (!MEM_BUSYWAIT) begin
          instr_nx       = MEM_RDATA;
          mem_read_nx    = 1'b0;
          instr_valid_nx = 1'b1;
          state_nx       = HOLD;
        end else begin
          cnt_enable = 1'b1;
          if (cnt_expired) begin
            mem_read_nx  = 1'b0;
            fetch_err_nx = 1'b1;
            state_nx     = IDLE;
          end
        end
      end
      HOLD: begin
        // FLUSH keeps PC_READY low, so the decoder take below never coincides with it.
        if (FLUSH || INSTR_READY) begin
          instr_valid_nx = 1'b0;
          state_nx       = IDLE;
        end
      end
      DRAIN: begin
        if (!MEM_BUSYWAIT) begin
          mem_read_nx = 1'b0;
          state_nx    = IDLE;
        end else begin
          cnt_enable = 1'b1;
          if (cnt_expired) begin
            mem_read_nx  = 1'b0;
            fetch_err_nx = 1'b1;
            state_nx     = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // Accepts only happen from IDLE or HOLD, and both start a new read.
    if (pc_accept) begin
      mem_addr_nx = PC_IN;
      instr_pc_nx = PC_IN;
      mem_read_nx = 1'b1;
      cnt_clear   = 1'b1;
      state_nx    = REQ;
    end
  end

  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      MEM_ADDR    <= '0;
      INSTR_PC    <= '0;
      INSTR       <= '0;
      MEM_READ    <= 1'b0;
      INSTR_VALID <= 1'b0;
      FETCH_ERR   <= 1'b0;
    end else begin
      state       <= state_nx;
      MEM_ADDR    <= mem_addr_nx;
      INSTR_PC    <= instr_pc_nx;
      INSTR       <= instr_nx;
      MEM_READ    <= mem_read_nx;
      INSTR_VALID <= instr_valid_nx;
      FETCH_ERR   <= fetch_err_nx;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vectors, corner sequences, random vs model.
module tb_instruction_fetch;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic [7:0]  mem_addr;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_busywait;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic pcr_seen;

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_W  (8),
    .INSTR_W (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .PC_IN        (pc_in),
    .PC_VALID     (pc_valid),
    .PC_READY     (pc_ready),
    .MEM_ADDR     (mem_addr),
    .MEM_READ     (mem_read),
    .MEM_RDATA    (mem_rdata),
    .MEM_BUSYWAIT (mem_busywait),
    .INSTR        (instr),
    .INSTR_PC     (instr_pc),
    .INSTR_VALID  (instr_valid),
    .INSTR_READY  (instr_ready),
    .FLUSH        (flush),
    .FETCH_ERR    (fetch_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs after posedge, record PC_READY, then sample just after the updating negedge.
  task automatic cyc(input logic pv, input logic [7:0] pc, input logic busy,
                     input logic [31:0] rdata, input logic ir, input logic fl);
    @(posedge clk);
    pc_valid = pv; pc_in = pc; mem_busywait = busy;
    mem_rdata = rdata; instr_ready = ir; flush = fl;
    #1;
    pcr_seen = pc_ready;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst_n = 1'b0;
    pc_valid = 1'b0; pc_in = '0; mem_busywait = 1'b0;
    mem_rdata = '0; instr_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(posedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        pv;
    logic [7:0]  pc;
    logic        busy;
    logic [31:0] rdata;
    logic        ir;
    logic        fl;
    logic        e_pcr;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [7:0]  e_ipc;
  } vec_t;

  vec_t vecs[11];

  // Transaction-level reference: an outstanding read (possibly doomed) and a held word.
  bit          m_reading, m_discard, m_holding, m_err;
  int          m_wait;
  logic [7:0]  m_addr, m_ipc;
  logic [31:0] m_instr;

  function automatic logic model_ready(input logic ir, input logic fl);
    return !fl && !m_reading && (!m_holding || ir);
  endfunction

  task automatic model_step(input logic pv, input logic [7:0] pc, input logic busy,
                            input logic [31:0] rdata, input logic ir, input logic fl);
    logic accept;
    accept = model_ready(ir, fl) && pv;
    if (m_reading) begin
      if (!busy) begin
        m_reading = 0;
        if (!m_discard && !fl) begin
          m_holding = 1;
          m_instr   = rdata;
        end
        m_discard = 0;
      end else if (fl && !m_discard) begin
        m_discard = 1;
        m_wait    = 0;
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_reading = 0;
          m_discard = 0;
          m_err     = 1;
        end
      end
    end else begin
      if (m_holding && (fl || ir)) m_holding = 0;
      if (accept) begin
        m_reading = 1;
        m_discard = 0;
        m_wait    = 0;
        m_addr    = pc;
        m_ipc     = pc;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pc_valid = 1'b0; pc_in = '0; mem_busywait = 1'b0;
    mem_rdata = '0; instr_ready = 1'b0; flush = 1'b0;

    // Reset state
    #3;
    check("reset_mem_read", mem_read, 1'b0);
    check("reset_instr_valid", instr_valid, 1'b0);
    check("reset_fetch_err", fetch_err, 1'b0);
    check("reset_instr", instr, 32'h0);
    check("reset_mem_addr", mem_addr, 8'h0);
    @(posedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming, then decoder backpressure
    vecs[0]  = '{1'b1, 8'h10, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 32'h0,        8'h10};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 32'hDEADBEEF, 8'h10};
    vecs[2]  = '{1'b1, 8'h11, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 32'hDEADBEEF, 8'h11};
    vecs[3]  = '{1'b1, 8'h12, 1'b0, 32'h00000011, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 32'h00000011, 8'h11};
    vecs[4]  = '{1'b1, 8'h12, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 32'h00000011, 8'h12};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 32'h00000012, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 32'h00000012, 8'h12};
    for (int i = 6; i < 10; i++)
      vecs[i] = '{1'b1, 8'h13, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 32'h00000012, 8'h12};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 32'h00000012, 8'h12};

    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].pv, vecs[i].pc, vecs[i].busy, vecs[i].rdata, vecs[i].ir, vecs[i].fl);
      check($sformatf("vec%0d_pc_ready", i), pcr_seen, vecs[i].e_pcr);
      check($sformatf("vec%0d_mem_read", i), mem_read, vecs[i].e_rd);
      check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_instr_valid", i), instr_valid, vecs[i].e_iv);
      check($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
      check($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].e_ipc);
    end

    // Three wait states: request held steady across them
    cyc(1'b1, 8'h30, 1'b1, 32'h0, 1'b0, 1'b0);
    check("ws_accept_mem_read", mem_read, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0);
      check("ws_mem_read", mem_read, 1'b1);
      check("ws_mem_addr", mem_addr, 8'h30);
      check("ws_pc_ready", pcr_seen, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
    check("ws_done_mem_read", mem_read, 1'b0);
    check("ws_done_instr_valid", instr_valid, 1'b1);
    check("ws_done_instr", instr, 32'hCAFEF00D);
    cyc(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0);
    check("ws_taken_instr_valid", instr_valid, 1'b0);

    // Timeout: busy for exactly TIMEOUT cycles aborts the read
    cyc(1'b1, 8'h31, 1'b1, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0);
      if (k < TIMEOUT) begin
        check("to_waiting_mem_read", mem_read, 1'b1);
        check("to_waiting_fetch_err", fetch_err, 1'b0);
      end
    end
    check("to_mem_read", mem_read, 1'b0);
    check("to_fetch_err", fetch_err, 1'b1);
    check("to_instr_valid", instr_valid, 1'b0);
    cyc(1'b1, 8'h32, 1'b0, 32'h0, 1'b0, 1'b0);
    check("to_next_pc_ready", pcr_seen, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 32'h01020304, 1'b0, 1'b0);
    check("to_next_instr", instr, 32'h01020304);
    check("to_next_instr_pc", instr_pc, 8'h32);
    check("to_next_valid", instr_valid, 1'b1);
    check("to_err_sticky", fetch_err, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while holding: no transfer, no new accept
    cyc(1'b1, 8'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 32'hAAAA5555, 1'b0, 1'b0);
    check("fh_hold_valid", instr_valid, 1'b1);
    cyc(1'b1, 8'h41, 1'b0, 32'h0, 1'b1, 1'b1);
    check("fh_pc_ready", pcr_seen, 1'b0);
    check("fh_instr_valid", instr_valid, 1'b0);
    check("fh_mem_read", mem_read, 1'b0);
    check("fh_instr_pc", instr_pc, 8'h40);
    cyc(1'b1, 8'h42, 1'b0, 32'h0, 1'b0, 1'b1);
    check("fi_pc_ready", pcr_seen, 1'b0);
    check("fi_mem_read", mem_read, 1'b0);

    // Flush during a busy read: drain, discard, then fetch 0x20 cleanly
    cyc(1'b1, 8'h50, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b1);
    check("fd_drain_mem_read", mem_read, 1'b1);
    cyc(1'b1, 8'h51, 1'b1, 32'h0, 1'b1, 1'b0);
    check("fd_drain_pc_ready", pcr_seen, 1'b0);
    check("fd_drain_valid", instr_valid, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 32'h12345678, 1'b1, 1'b0);
    check("fd_discard_mem_read", mem_read, 1'b0);
    check("fd_discard_valid", instr_valid, 1'b0);
    check("fd_discard_instr", instr, 32'hAAAA5555);
    cyc(1'b1, 8'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    check("fd_next_pc_ready", pcr_seen, 1'b1);
    check("fd_next_mem_addr", mem_addr, 8'h20);
    cyc(1'b0, 8'h00, 1'b0, 32'h0BADC0DE, 1'b0, 1'b0);
    check("fd_next_instr", instr, 32'h0BADC0DE);
    check("fd_next_instr_pc", instr_pc, 8'h20);
    check("fd_next_valid", instr_valid, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush on a read that completes the same cycle
    cyc(1'b1, 8'h60, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 32'h77777777, 1'b0, 1'b1);
    check("fz_mem_read", mem_read, 1'b0);
    check("fz_valid", instr_valid, 1'b0);
    check("fz_instr", instr, 32'h0BADC0DE);

    // Asynchronous reset in the middle of a read
    cyc(1'b1, 8'h04, 1'b1, 32'h0, 1'b0, 1'b0);
    check("ar_pre_mem_read", mem_read, 1'b1);
    check("ar_pre_fetch_err", fetch_err, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_mem_read", mem_read, 1'b0);
    check("ar_instr_valid", instr_valid, 1'b0);
    check("ar_fetch_err", fetch_err, 1'b0);
    check("ar_mem_addr", mem_addr, 8'h0);
    check("ar_instr_pc", instr_pc, 8'h0);
    pc_valid = 1'b0; mem_busywait = 1'b0;
    @(negedge clk);
    @(posedge clk);
    rst_n = 1'b1;

    // Random traffic against the reference model, with increasingly sticky memory
    m_reading = 0; m_discard = 0; m_holding = 0; m_err = 0; m_wait = 0;
    m_addr = '0; m_ipc = '0; m_instr = '0;
    for (int ph = 0; ph < 3; ph++) begin
      int busy_pct;
      busy_pct = (ph == 0) ? 30 : (ph == 1) ? 70 : 97;
      for (int n = 0; n < 700; n++) begin
        logic        pv, busy, ir, fl, exp_pcr;
        logic [7:0]  pc;
        logic [31:0] rd;
        pv   = ($urandom_range(0, 99) < 70);
        pc   = 8'($urandom);
        busy = ($urandom_range(0, 99) < busy_pct);
        rd   = $urandom;
        ir   = ($urandom_range(0, 99) < 70);
        fl   = ($urandom_range(0, 99) < 5);
        exp_pcr = model_ready(ir, fl);
        cyc(pv, pc, busy, rd, ir, fl);
        model_step(pv, pc, busy, rd, ir, fl);
        check("rnd_pc_ready", pcr_seen, exp_pcr);
        check("rnd_mem_read", mem_read, m_reading);
        check("rnd_mem_addr", mem_addr, m_addr);
        check("rnd_instr_valid", instr_valid, m_holding);
        check("rnd_instr", instr, m_instr);
        check("rnd_instr_pc", instr_pc, m_ipc);
        check("rnd_fetch_err", fetch_err, m_err);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
